mac_vector_loader: RTL
======================

# mac_vector_loader

Upstream feeder for the pipelined 16-lane MAC. Accepts element pairs (a[i], b[i]) one per beat on a valid/ready stream and assembles them into two N-element parallel vectors. Completed vectors are presented to the MAC through a double-buffered valid/ready output. Short frames are zero-padded and length violations are flagged, so the MAC never sees a partially written vector.

## Interface
- N, 16, elements per vector (2..64)
- W, 32, signed element width
- CW, 16, width of frame counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_a  in  W  signed element of vector A
- s_b  in  W  signed element of vector B
- s_last  in  1  final beat of frame
- vec_a  out  N x W  assembled vector A, element i = i-th beat
- vec_b  out  N x W  assembled vector B
- vec_valid  out  1  vec_a/vec_b hold a complete frame
- vec_ready  in  1  downstream takes frame when vec_valid && vec_ready
- frame_err  out  1  one-cycle pulse on length violation
- frame_cnt  out  CW  frames delivered to output, wraps modulo 2^CW

## Operation
- Two banks:
  - Fill bank: buffers fa/fb, index idx (0..N-1), flag fill_full.
  - Output bank: vec_a/vec_b, flag vec_valid.
- s_ready = !fill_full.
- Accepted beat: writes fa[idx] = s_a and fb[idx] = s_b.
  - Frame completes when s_last = 1 or idx = N-1.
    - On completion: fill_full <= 1, idx <= 0.
    - Otherwise: idx <= idx+1.
- Length checks:
  - Early last (s_last at idx < N-1): frame completes. Unwritten entries stay 0 (zero-padded). frame_err pulses.
  - Missing last (idx = N-1, s_last = 0): frame completes at N beats. frame_err pulses. The next beat starts a new frame.
  - s_last at idx = N-1: normal, no error.
- Transfer happens on an edge where fill_full = 1 and (vec_valid = 0 or vec_ready = 1):
  - vec_a/vec_b <= fa/fb; vec_valid <= 1; frame_cnt <= frame_cnt+1.
  - fa/fb cleared to 0; fill_full <= 0.
- Consume without transfer (vec_valid && vec_ready && !fill_full): vec_valid <= 0. vec_a/vec_b hold their last values.
- Simultaneous consume and transfer: the new frame replaces the old one; vec_valid stays 1.
- vec_a/vec_b are stable while vec_valid && !vec_ready.
- Reset (any time, including mid-frame):
  - fa/fb, vec_a/vec_b, idx, frame_cnt = 0; fill_full = 0; vec_valid = 0; frame_err = 0.
  - Therefore s_ready = 1 during and after reset.
  - A partial frame is discarded without error.
- Arithmetic: no arithmetic on data; elements pass bit-exact. frame_cnt wraps from 2^CW-1 to 0.

## Timing
- Completing beat accepted at edge T → fill_full = 1 and s_ready = 0 after T.
- Transfer at T+1 if the output slot is free → vec_valid = 1 in the cycle after T+1. Minimum latency from last beat to vec_valid is 2 edges.
- Sustained throughput with vec_ready held at 1: one frame per N+1 cycles (one s_ready bubble per frame).
- Back-pressure: if vec_valid && !vec_ready when fill_full sets, s_ready stays 0 until the edge after vec_ready is seen.
- frame_err is registered; it is high for exactly the cycle after the completing beat's edge.
- frame_cnt updates on the same edge as the transfer.
- All outputs are registered except s_ready, which is a direct function of the fill_full register.

## Test plan
- Nominal frame: N = 16, vec_ready = 1; beats a = i+1, b = -(i+1), s_last on beat 15.
  - vec_valid rises 2 edges after beat 15.
  - vec_a[i] = i+1, vec_b[i] = -(i+1).
  - frame_cnt = 1, frame_err never asserted.
- Short frame: 5 beats of a = 7, b = 3, s_last on beat 4.
  - vec_a[0..4] = 7, vec_b[0..4] = 3, vec_a/vec_b[5..15] = 0.
  - frame_err pulses for one cycle.
- Missing last then resync: 20 beats with s_last only on beat 19.
  - Frame 1: beats 0..15, frame_err pulses.
  - Frame 2: beats 16..19 in elements 0..3, zeros elsewhere, frame_err pulses again.
- Back-pressure: vec_ready = 0 while three frames are sent.
  - After frame 2 completes, s_ready stays 0 and vec_a still holds frame 1 unchanged.
  - Raise vec_ready for one cycle: frame 2 moves to the output, s_ready returns to 1, frame 3 is accepted, nothing is lost or duplicated.
- Mid-frame reset: assert rst after 9 beats, then send a full 16-beat frame.
  - During reset: s_ready = 1, vec_valid = 0, frame_cnt = 0.
  - The delivered frame contains only post-reset data.
- Throughput and wrap: CW = 4, vec_ready = 1, 17 back-to-back frames with s_valid held high.
  - One s_ready-low cycle per 17 cycles.
  - frame_cnt reads 0 after frame 16 and 1 after frame 17.

Source files
------------

// File: rtl/mac_vector_loader.sv
// Element-pair stream to N-wide vector assembler feeding the MAC.
// Fill bank collects one frame while the output bank holds the previous one.
module mac_vector_loader #(
    parameter int N  = 16,
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [W-1:0]          s_a,
    input  logic [W-1:0]          s_b,
    input  logic                  s_last,
    output logic [N-1:0][W-1:0]   vec_a,
    output logic [N-1:0][W-1:0]   vec_b,
    output logic                  vec_valid,
    input  logic                  vec_ready,
    output logic                  frame_err,
    output logic [CW-1:0]         frame_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef logic [N-1:0][W-1:0] vec_t;

    vec_t          fa_q, fa_d;
    vec_t          fb_q, fb_d;
    vec_t          va_q, va_d;
    vec_t          vb_q, vb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          full_q, full_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic accept;
    logic at_end;
    logic complete;
    logic xfer;

    assign s_ready  = !full_q;
    assign accept   = s_valid && !full_q;
    assign at_end   = (idx_q == IW'(N - 1));
    assign complete = accept && (s_last || at_end);
    assign xfer     = full_q && (!vld_q || vec_ready);

    always_comb begin
        fa_d   = fa_q;
        fb_d   = fb_q;
        va_d   = va_q;
        vb_d   = vb_q;
        idx_d  = idx_q;
        full_d = full_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        // Error when the last flag and the N-th beat disagree.
        err_d  = complete && (s_last != at_end);

        if (accept) begin
            fa_d[idx_q] = s_a;
            fb_d[idx_q] = s_b;
            idx_d       = complete ? '0 : idx_q + IW'(1);
            full_d      = complete;
        end

        // accept needs !full_q and xfer needs full_q, so they never collide.
        if (xfer) begin
            va_d   = fa_q;
            vb_d   = fb_q;
            vld_d  = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            fa_d   = '0;
            fb_d   = '0;
            full_d = 1'b0;
        end else if (vld_q && vec_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_q   <= '0;
            fb_q   <= '0;
            va_q   <= '0;
            vb_q   <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            va_q   <= va_d;
            vb_q   <= vb_d;
            idx_q  <= idx_d;
            full_q <= full_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign vec_a     = va_q;
    assign vec_b     = vb_q;
    assign vec_valid = vld_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule
